// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// One grant per frame; further grants are held off until the frame has finished.
module uart_tx_arbiter #(
  parameter int N_REQ           = 4,
  parameter int UART_DATA_WIDTH = 8,
  parameter int FRAME_CYCLES    = 1200,
  parameter int CNT_W           = $clog2(FRAME_CYCLES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*UART_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                   req_ready,
  output logic [UART_DATA_WIDTH-1:0]         tx_data,
  output logic                               tx_send,
  output logic                               busy,
  output logic [$clog2(N_REQ)-1:0]           grant_id
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                     state_reg;
  logic [CNT_W-1:0]           timer_reg;
  logic [PTR_W-1:0]           rr_ptr_reg;
  logic [PTR_W-1:0]           rr_ptr_next;
  logic [PTR_W-1:0]           grant_id_reg;
  logic [PTR_W-1:0]           winner;
  logic [UART_DATA_WIDTH-1:0] tx_data_reg;
  logic                       tx_send_reg;
  logic                       grant_fire;

  logic [UART_DATA_WIDTH-1:0] data_arr   [N_REQ];
  logic [PTR_W-1:0]           cand_idx   [N_REQ];
  logic [N_REQ-1:0]           cand_valid;

  // Candidate gi is the requester gi places above rr_ptr, wrapping at N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [PTR_W:0] sum;
    assign data_arr[gi]   = req_data[gi*UART_DATA_WIDTH +: UART_DATA_WIDTH];
    assign sum            = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
    assign cand_idx[gi]   = (sum >= (PTR_W+1)'(N_REQ)) ? (PTR_W)'(sum - (PTR_W+1)'(N_REQ))
                                                        : sum[PTR_W-1:0];
    assign cand_valid[gi] = req_valid[cand_idx[gi]];
  end

  // Scan from the farthest candidate down so the nearest valid one wins.
  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) winner = cand_idx[k];
    end
  end

  assign rr_ptr_next = (winner == (PTR_W)'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign grant_fire  = (state_reg == IDLE) && (|req_valid) && !rst;
  assign req_ready   = grant_fire ? ({{(N_REQ-1){1'b0}}, 1'b1} << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      tx_data_reg  <= '0;
      tx_send_reg  <= 1'b0;
    end else begin
      tx_send_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            tx_data_reg  <= data_arr[winner];
            grant_id_reg <= winner;
            rr_ptr_reg   <= rr_ptr_next;
            tx_send_reg  <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          timer_reg <= (CNT_W)'(FRAME_CYCLES - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          // Zero test precedes the decrement, so the timer never wraps.
          if (timer_reg == '0) state_reg <= IDLE;
          else                 timer_reg <= timer_reg - 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_send  = tx_send_reg;
  assign busy     = (state_reg != IDLE);
  assign grant_id = grant_id_reg;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit scheduler that shares one UART_MIKE transmitter between `N_REQ` requesters. Grants one requester at a time, latches its byte, and drives the UART's `tx_data`/`tx_send` pair. It then holds off all further grants for a programmed frame time so that a frame is never truncated or restarted mid-flight. It sits between the requesting agents and the UART's `tx_data`/`tx_send` inputs.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters; range 2..16.
- `UART_DATA_WIDTH`, 8, byte width; must match the UART.
- `FRAME_CYCLES`, 1200, clock cycles from the `tx_send` pulse until the UART line is idle after the stop bit; must be ≥ 2.
- `CNT_W`, `$clog2(FRAME_CYCLES+1)`, frame timer width.

Ports:
- `clk`, in, 1, single clock; all logic is rising-edge.
- `rst`, in, 1, reset; synchronous, active-high.
- `req_valid`, in, `N_REQ`, bit i set means requester i has a byte pending.
- `req_data`, in, `N_REQ*UART_DATA_WIDTH`, byte of requester i at bits `[i*W +: W]`.
- `req_ready`, out, `N_REQ`, one-hot accept strobe; byte i is consumed on the edge where `req_valid[i] & req_ready[i]`.
- `tx_data`, out, `UART_DATA_WIDTH`, byte to the UART, registered.
- `tx_send`, out, 1, single-cycle start pulse to the UART, registered.
- `busy`, out, 1, high whenever the state is not IDLE.
- `grant_id`, out, `$clog2(N_REQ)`, index of the last granted requester.

## Operation
- FSM states: IDLE, SEND, WAIT.
- **IDLE:**
  - If any `req_valid` bit is set, select the winner by round-robin.
  - Search starts at `rr_ptr` and moves upward with wrap-around.
  - Assert `req_ready[winner]` combinationally in this cycle only.
  - On the edge:
    - `tx_data <= req_data[winner]`
    - `grant_id <= winner`
    - `rr_ptr <= (winner+1) mod N_REQ`
    - next state is SEND.
  - If no request is pending, stay in IDLE; `req_ready` is all zeros.
- **SEND:** `tx_send` = 1 for exactly this cycle. The frame timer loads `FRAME_CYCLES-1`. Next state is WAIT.
- **WAIT:**
  - `tx_send` = 0; the timer decrements by 1 each cycle.
  - When the timer is 0, go to IDLE on that edge.
  - `req_ready` stays 0 throughout.
- `tx_data` stays constant from SEND until the next grant. The UART samples `tx_data` combinationally for the whole frame, so `tx_data` must never change while `busy` is high.
- `req_valid` may drop before it is granted; that request is simply not served and no grant is issued.
- `req_ready` is never asserted in SEND or WAIT, and never to a requester whose `req_valid` is low.
- After a grant to requester k, requester k has the lowest priority in the next arbitration.
- Arithmetic:
  - The timer is unsigned `CNT_W` bits and never underflows; the compare to 0 occurs before any decrement.
  - `rr_ptr` wraps from `N_REQ-1` to 0; for non-power-of-2 `N_REQ`, values ≥ `N_REQ` are never reachable.

## Timing
- Reset values: state IDLE, `tx_data` 0, `tx_send` 0, `busy` 0, `grant_id` 0, `req_ready` 0, `rr_ptr` 0, timer 0.
- Latency: grant in cycle G, `tx_send` high in cycle G+1, WAIT spans cycles G+2 … G+FRAME_CYCLES+1, IDLE in cycle G+FRAME_CYCLES+2.
- Minimum spacing between consecutive `tx_send` pulses is `FRAME_CYCLES+2` cycles. `tx_send` therefore always has low cycles between pulses, which the UART's edge detector requires.
- `busy` rises the cycle after the grant and falls the cycle after the timer reaches 0.
- Reset mid-operation (SEND or WAIT): next edge gives state IDLE and `tx_send` 0. No grant is issued in the cycle `rst` is high. Any frame already started is the UART's concern, since it is reset on its own.
- Simultaneous requests: exactly one grant per IDLE cycle. Other requests keep waiting with `req_valid` held.
- A requester re-asserting `req_valid` in the same cycle its previous byte was consumed is legal; it competes in the next IDLE.

## Test plan
1. Single request: `rst` released, `req_valid`=0001 and `req_data[0]`=0xA5 in cycle 5. Expect `req_ready`=0001 in cycle 5, `tx_data`=0xA5 and `tx_send`=1 in cycle 6 only, `busy`=1 from 6 to 6+`FRAME_CYCLES`, and IDLE at cycle 7+`FRAME_CYCLES`.
2. All four requesting continuously with bytes 0x10/0x21/0x32/0x43. Expect grant order 0,1,2,3,0 and `tx_send` pulses exactly `FRAME_CYCLES+2` apart, with `tx_data` matching each grant.
3. Fairness: requesters 1 and 3 held high continuously. Expect alternating grants 1,3,1,3; requester 1 never wins twice in a row.
4. Withdrawn request: `req_valid[2]` high only during WAIT, then dropped. Expect no grant to 2, `req_ready[2]` never high, and the FSM stays in IDLE.
5. Reset in WAIT: assert `rst` for 1 cycle at timer = `FRAME_CYCLES/2`. Expect `busy`=0 and `tx_send`=0 next cycle, `rr_ptr`=0, and a following request from 2 and 0 grants 0 first.
6. `FRAME_CYCLES`=2 build: back-to-back requests. Expect `tx_send` period 4 cycles and `tx_data` stable between pulses.
